// File: rtl/branch_predictor_if.sv
//------------------------------------------------------------------------------
// branch_predictor_if
// Groups the fetch/decode/hazard-side signals of the branch predictor.
// The master (pipeline) drives stage controls and decode resolution.
// The slave (predictor) returns the predicted PC and the miss flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface branch_predictor_if;
  logic        stall_f_i;
  logic        stall_d_i;
  logic        flush_d_i;
  logic [31:0] pc_f_i;
  logic        branch_d_i;
  logic        pc_src_d_i;
  logic [31:0] pc_branch_d_i;
  logic [31:0] predict_pc_o;
  logic        predict_miss_o;

  modport master (
    output stall_f_i, stall_d_i, flush_d_i, pc_f_i,
    output branch_d_i, pc_src_d_i, pc_branch_d_i,
    input  predict_pc_o, predict_miss_o
  );

  modport slave (
    input  stall_f_i, stall_d_i, flush_d_i, pc_f_i,
    input  branch_d_i, pc_src_d_i, pc_branch_d_i,
    output predict_pc_o, predict_miss_o
  );
endinterface

`default_nettype wire

// File: rtl/branch_predictor.sv
//------------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with 2-bit saturating counters. Predicts the next fetch
// PC combinationally, tracks the prediction into decode, flags mispredictions
// against the decode-stage resolution and trains the table once per
// decoded instruction.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module branch_predictor #(
  parameter  int ENTRIES    = 64,
  localparam int INDEX_BITS = $clog2(ENTRIES)
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  branch_predictor_if.slave bp
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  // BTB storage
  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [29:0]           target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];

  // Decode tracking register
  logic                  dec_valid_q;
  logic                  dec_taken_q;
  logic [31:0]           dec_pred_pc_q;
  logic [INDEX_BITS-1:0] dec_index_q;
  logic [TAG_BITS-1:0]   dec_tag_q;

  // Fetch-side lookup
  logic [INDEX_BITS-1:0] idx_f;
  logic [TAG_BITS-1:0]   tag_f;
  logic                  hit_f;
  logic                  taken_f;
  logic [31:0]           pc_plus4_f;

  assign idx_f      = bp.pc_f_i[INDEX_BITS+1:2];
  assign tag_f      = bp.pc_f_i[31:INDEX_BITS+2];
  assign hit_f      = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign taken_f    = hit_f && ctr_q[idx_f][1];
  assign pc_plus4_f = bp.pc_f_i + 32'd4;

  assign bp.predict_pc_o = taken_f ? {target_q[idx_f], 2'b00} : pc_plus4_f;

  // A non-branch that was predicted taken is an alias; fetch recovers via
  // pc+4 in decode because pc_src is low for it.
  assign bp.predict_miss_o = dec_valid_q &&
    ((bp.branch_d_i && (bp.pc_src_d_i != dec_taken_q)) ||
     (bp.branch_d_i && bp.pc_src_d_i && dec_taken_q &&
      (bp.pc_branch_d_i != dec_pred_pc_q)) ||
     (!bp.branch_d_i && dec_taken_q));

  // Training: only for a live decode instruction that is leaving decode.
  logic       train_en;
  logic       entry_match_d;
  logic [1:0] ctr_cur;
  logic [1:0] ctr_d;

  assign train_en      = dec_valid_q && !bp.stall_d_i && !bp.flush_d_i;
  assign entry_match_d = valid_q[dec_index_q] && (tag_q[dec_index_q] == dec_tag_q);
  assign ctr_cur       = ctr_q[dec_index_q];

  // Next counter value: fresh allocation starts weakly taken, else saturate.
  always_comb begin
    ctr_d = ctr_cur;
    if (bp.pc_src_d_i) begin
      if (!entry_match_d)        ctr_d = 2'b10;
      else if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
    end else if (ctr_cur != 2'b00) begin
      ctr_d = ctr_cur - 2'd1;
    end
  end

  // BTB update; lookup in the same cycle sees the pre-update contents.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (train_en) begin
      if (bp.branch_d_i) begin
        ctr_q[dec_index_q] <= ctr_d;
        if (bp.pc_src_d_i) begin
          valid_q[dec_index_q]  <= 1'b1;
          tag_q[dec_index_q]    <= dec_tag_q;
          target_q[dec_index_q] <= bp.pc_branch_d_i[31:2];
        end
      end else if (dec_taken_q) begin
        valid_q[dec_index_q] <= 1'b0;
      end
    end
  end

  // Decode tracking register: flush beats stall beats load.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      dec_valid_q   <= 1'b0;
      dec_taken_q   <= 1'b0;
      dec_pred_pc_q <= '0;
      dec_index_q   <= '0;
      dec_tag_q     <= '0;
    end else if (bp.flush_d_i) begin
      dec_valid_q <= 1'b0;
      dec_taken_q <= 1'b0;
    end else if (!bp.stall_d_i) begin
      dec_valid_q   <= 1'b1;
      dec_taken_q   <= taken_f;
      dec_pred_pc_q <= bp.predict_pc_o;
      dec_index_q   <= idx_f;
      dec_tag_q     <= tag_f;
    end
  end

  // Fetch stall never gates this block (decode is always stalled with it);
  // the byte-offset bits of word-aligned PCs carry no information.
  logic unused_bits;
  assign unused_bits = ^{bp.stall_f_i, bp.pc_f_i[1:0], bp.pc_branch_d_i[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
//------------------------------------------------------------------------------
// tb_branch_predictor
// Directed vector table, random traffic against a behavioural model, and
// asynchronous reset checks for branch_predictor (4-entry configuration).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_branch_predictor;
  localparam int ENT = 4;
  localparam int IB  = $clog2(ENT);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(.ENTRIES(ENT)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bp    (bp_if)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: table of entries plus the instruction held in decode
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  bit          t_valid, t_taken;
  logic [31:0] t_pc;
  int          t_idx;
  int unsigned t_tag;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return pc >> (2 + IB);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    t_valid = 0; t_taken = 0; t_pc = 0; t_idx = 0; t_tag = 0;
  endfunction

  function automatic bit model_taken(logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_pc(logic [31:0] pc);
    return model_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  // Wrong whenever the resolved direction or target differs from the guess.
  function automatic bit model_miss(bit br, bit src, logic [31:0] pcb);
    if (!t_valid) return 0;
    if (br) return (src != t_taken) || (src && (pcb != t_pc));
    return t_taken;
  endfunction

  function automatic void model_edge(bit sd, bit fd, logic [31:0] pc,
                                     bit br, bit src, logic [31:0] pcb);
    bit          tk  = model_taken(pc);
    logic [31:0] ppc = model_pc(pc);
    if (t_valid && !sd && !fd) begin
      if (br) begin
        if (src) begin
          if (!(m_valid[t_idx] && m_tag[t_idx] == t_tag)) m_ctr[t_idx] = 2;
          else if (m_ctr[t_idx] < 3) m_ctr[t_idx] = m_ctr[t_idx] + 1;
          m_valid[t_idx] = 1;
          m_tag[t_idx]   = t_tag;
          m_tgt[t_idx]   = pcb & 32'hFFFF_FFFC;
        end else if (m_ctr[t_idx] > 0) begin
          m_ctr[t_idx] = m_ctr[t_idx] - 1;
        end
      end else if (t_taken) begin
        m_valid[t_idx] = 0;
      end
    end
    if (fd) begin
      t_valid = 0; t_taken = 0;
    end else if (!sd) begin
      t_valid = 1; t_taken = tk; t_pc = ppc; t_idx = idx_of(pc); t_tag = tag_of(pc);
    end
  endfunction

  task automatic chk32(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic chk1(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // One clock: drive after the edge, sample on the falling edge, model the edge.
  task automatic cycle(bit sd, bit fd, bit sf, logic [31:0] pc, bit br, bit src,
                       logic [31:0] pcb, output logic [31:0] gpc, output logic gmiss);
    logic [31:0] epc;
    bit          emiss;
    bp_if.stall_d_i     = sd;
    bp_if.flush_d_i     = fd;
    bp_if.stall_f_i     = sf;
    bp_if.pc_f_i        = pc;
    bp_if.branch_d_i    = br;
    bp_if.pc_src_d_i    = src;
    bp_if.pc_branch_d_i = pcb;
    epc   = model_pc(pc);
    emiss = model_miss(br, src, pcb);
    @(negedge clk);
    gpc   = bp_if.predict_pc_o;
    gmiss = bp_if.predict_miss_o;
    chk32("model_pc", gpc, epc);
    chk1("model_miss", gmiss, emiss);
    @(posedge clk);
    model_edge(sd, fd, pc, br, src, pcb);
    #1;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  typedef struct {
    bit          sd;
    bit          fd;
    logic [31:0] pc;
    bit          br;
    bit          src;
    logic [31:0] pcb;
    logic [31:0] epc;
    bit          emiss;
  } vec_t;

  function automatic vec_t mk(bit sd, bit fd, logic [31:0] pc, bit br, bit src,
                              logic [31:0] pcb, logic [31:0] epc, bit em);
    vec_t v;
    v = '{sd, fd, pc, br, src, pcb, epc, em};
    return v;
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [31:0] gpc;
    logic        gmiss;

    //            sd fd  pc_f          br src pc_branch     exp_pc         miss
    vecs.push_back(mk(0, 0, 32'h100,      0, 0, 32'h0,   32'h104,       0)); // cold fetch
    vecs.push_back(mk(0, 0, 32'h104,      1, 1, 32'h200, 32'h108,       1)); // cold taken -> miss
    vecs.push_back(mk(0, 1, 32'h200,      0, 0, 32'h0,   32'h204,       0)); // wrong path flushed
    vecs.push_back(mk(0, 0, 32'h100,      0, 0, 32'h0,   32'h200,       0)); // trained: predict 0x200
    vecs.push_back(mk(0, 0, 32'h200,      1, 1, 32'h200, 32'h204,       0)); // correct, ctr 11
    vecs.push_back(mk(0, 0, 32'h100,      0, 0, 32'h0,   32'h200,       0));
    vecs.push_back(mk(0, 0, 32'h200,      1, 1, 32'h200, 32'h204,       0)); // third taken
    vecs.push_back(mk(0, 0, 32'h100,      0, 0, 32'h0,   32'h200,       0));
    vecs.push_back(mk(0, 0, 32'h200,      1, 0, 32'h200, 32'h204,       1)); // not taken -> miss
    vecs.push_back(mk(0, 1, 32'h104,      0, 0, 32'h0,   32'h108,       0));
    vecs.push_back(mk(0, 0, 32'h100,      0, 0, 32'h0,   32'h200,       0)); // ctr 10 still taken
    vecs.push_back(mk(0, 0, 32'h110,      1, 1, 32'h300, 32'h114,       1)); // alias miss, target change
    vecs.push_back(mk(0, 1, 32'h300,      0, 0, 32'h0,   32'h304,       0)); // flush -> miss 0
    vecs.push_back(mk(0, 0, 32'h100,      0, 0, 32'h0,   32'h300,       0)); // new target
    vecs.push_back(mk(0, 0, 32'h104,      0, 0, 32'h0,   32'h108,       1)); // non-branch taken
    vecs.push_back(mk(0, 1, 32'h100,      0, 0, 32'h0,   32'h104,       0)); // entry invalidated
    vecs.push_back(mk(0, 0, 32'h100,      0, 0, 32'h0,   32'h104,       0));
    vecs.push_back(mk(1, 0, 32'h104,      1, 1, 32'h200, 32'h108,       1)); // stalled miss
    vecs.push_back(mk(1, 0, 32'h104,      1, 1, 32'h200, 32'h108,       1));
    vecs.push_back(mk(1, 0, 32'h104,      1, 1, 32'h200, 32'h108,       1));
    vecs.push_back(mk(0, 0, 32'h104,      1, 1, 32'h200, 32'h108,       1)); // release: train once
    vecs.push_back(mk(0, 1, 32'h200,      0, 0, 32'h0,   32'h204,       0));
    vecs.push_back(mk(0, 0, 32'h100,      0, 0, 32'h0,   32'h200,       0));
    vecs.push_back(mk(0, 0, 32'h200,      1, 0, 32'h200, 32'h204,       1)); // ctr 10 -> 01
    vecs.push_back(mk(0, 1, 32'h104,      0, 0, 32'h0,   32'h108,       0));
    vecs.push_back(mk(0, 0, 32'h100,      0, 0, 32'h0,   32'h104,       0)); // single train proven
    vecs.push_back(mk(0, 0, 32'h104,      0, 0, 32'h0,   32'h108,       0));
    vecs.push_back(mk(0, 0, 32'hFFFF_FFFC, 0, 0, 32'h0,  32'h0000_0000, 0)); // pc+4 wraps

    bp_if.stall_f_i = 0; bp_if.stall_d_i = 0; bp_if.flush_d_i = 0;
    bp_if.branch_d_i = 0; bp_if.pc_src_d_i = 0; bp_if.pc_branch_d_i = 0;
    bp_if.pc_f_i = 32'h0040_0000;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    chk32("reset_pc", bp_if.predict_pc_o, 32'h0040_0004);
    chk1("reset_miss", bp_if.predict_miss_o, 1'b0);
    model_reset();
    @(posedge clk); #1;
    chk32("reset_pc_held", bp_if.predict_pc_o, 32'h0040_0004);
    rst_n = 1'b1;

    // Directed vector table
    for (int k = 0; k < vecs.size(); k++) begin
      cycle(vecs[k].sd, vecs[k].fd, 1'b0, vecs[k].pc, vecs[k].br, vecs[k].src,
            vecs[k].pcb, gpc, gmiss);
      chk32($sformatf("vec%0d_pc", k), gpc, vecs[k].epc);
      chk1($sformatf("vec%0d_miss", k), gmiss, vecs[k].emiss);
    end

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit sd = ($urandom_range(0, 4) == 0);
      bit fd = ($urandom_range(0, 9) == 0);
      bit sf = sd && ($urandom_range(0, 1) == 1);
      cycle(sd, fd, sf, rand_pc(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rand_pc(), gpc, gmiss);
    end

    // Mid-operation asynchronous reset discards history
    for (int n = 0; n < 4; n++)
      cycle(1'b0, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 32'h240, gpc, gmiss);
    bp_if.pc_f_i = 32'h100; bp_if.branch_d_i = 1; bp_if.pc_src_d_i = 1;
    bp_if.pc_branch_d_i = 32'h280;
    rst_n = 1'b0;
    #1;
    chk32("midreset_pc", bp_if.predict_pc_o, 32'h104);
    chk1("midreset_miss", bp_if.predict_miss_o, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, gpc, gmiss);
    chk32("after_reset_pc", gpc, 32'h104);
    for (int n = 0; n < 100; n++)
      cycle(1'b0, 1'($urandom_range(0, 7) == 0), 1'b0, rand_pc(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rand_pc(), gpc, gmiss);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor feeding the fetch stage's next-PC selection. It looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and produces the predicted next PC. It tracks each prediction into decode, compares it with the branch outcome resolved there, raises a miss so fetch takes the resolved PC, and trains the tables.

## Interface

- ENTRIES, 64, number of BTB entries; power of two, minimum 4.
- INDEX_BITS, $clog2(ENTRIES), index width; derived, not overridden.

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; one clock, asynchronous, active-low.
- stall_f_i  input  1  fetch stage stalled.
- stall_d_i  input  1  decode stage stalled; holds the decode tracking register.
- flush_d_i  input  1  decode stage flushed; clears the decode tracking register.
- pc_f_i  input  32  current fetch PC.
- branch_d_i  input  1  decode-stage instruction is a conditional branch.
- pc_src_d_i  input  1  decode-stage branch resolved taken.
- pc_branch_d_i  input  32  resolved branch target in decode.
- predict_pc_o  output  32  predicted next fetch PC; combinational.
- predict_miss_o  output  1  decode-stage prediction wrong; combinational.

## Operation

- Index = pc[INDEX_BITS+1:2]. Tag = pc[31:INDEX_BITS+2].
- Each entry holds: valid (1), tag, target (30 bits; the low 2 bits are implicitly 00), ctr (2).
- Lookup is combinational on pc_f_i. hit = valid & tag match. taken_f = hit & ctr[1].
- predict_pc_o = taken_f ? {target,2'b00} : pc_f_i + 4. The add is 32-bit and wraps modulo 2^32.
- Decode tracking register holds valid_d, taken_d, pred_pc_d (32) and index_d.
  - It loads {1, taken_f, predict_pc_o, index} when !stall_d_i.
  - flush_d_i has priority over stall and load: it sets valid_d = 0 and taken_d = 0.
  - stall_f_i does not affect the register. The hazard unit never stalls fetch without stalling decode.
- predict_miss_o = valid_d & ((branch_d_i & (pc_src_d_i != taken_d)) | (branch_d_i & pc_src_d_i & taken_d & (pc_branch_d_i != pred_pc_d)) | (!branch_d_i & taken_d)).
  - The last term is an aliased non-branch predicted taken. Fetch then uses pc_plus_4_d because pc_src_d = 0.
- Training happens only when valid_d & !stall_d_i & !flush_d_i, so each decode instruction trains exactly once.
  - Branch: entry[index_d].ctr saturates up when pc_src_d_i = 1 and down otherwise; 11 stays 11, 00 stays 00.
  - If taken, the entry is also written with valid = 1, the tag of pc_branch source, and target = pc_branch_d_i[31:2]. The tag is carried as tag_d in the tracking register alongside index_d.
  - A newly allocated entry (previous tag mismatch or invalid) gets ctr = 10.
  - Non-branch with taken_d = 1: entry[index_d].valid cleared.
  - Non-branch with taken_d = 0: no update.
- Lookup and training to the same index in the same cycle: lookup sees pre-update contents; there is no bypass.

## Timing

- Prediction latency 0 cycles: predict_pc_o follows pc_f_i combinationally.
- Miss detection in the cycle the instruction is in decode. Penalty is 1 cycle: the wrong-path fetch is flushed by the hazard unit via flush_d_i on the next edge.
- Table updates become visible to lookup on the cycle after the training edge.
- Reset (asynchronous, rst_i = 0):
  - All valid = 0; all ctr = 01; valid_d = 0, taken_d = 0, pred_pc_d = 0.
  - Hence predict_miss_o = 0 and predict_pc_o = pc_f_i + 4 during and after reset until training.
- Reset mid-operation discards all history. No partial updates; every write is a single-edge update.
- While stall_d_i = 1, predict_miss_o stays valid and stable for the held instruction, and no training occurs.

## Test plan

- Reset with pc_f_i = 0x0040_0000 -> predict_pc_o = 0x0040_0004, predict_miss_o = 0.
- Cold taken branch at 0x100 to target 0x200:
  - Decode cycle: branch_d = 1, pc_src_d = 1 -> miss = 1.
  - Next visit to 0x100 -> predict_pc_o = 0x200, with no miss in decode.
- Counter saturation: the branch at 0x100 is taken 3 times, then not taken once.
  - After those 4 outcomes, fetch of 0x100 still predicts 0x200 (ctr 10).
  - The not-taken resolution itself raises miss = 1.
- Aliasing: ENTRIES = 4; train a taken branch at 0x100, then fetch 0x110 (same index, different tag) -> predict_pc_o = 0x114.
  - Force a tag collision to exercise the non-branch term: predicted taken with branch_d = 0 -> miss = 1, then entry invalidated.
- Stall/flush:
  - Hold stall_d_i = 1 for 3 cycles with a mispredicted branch -> miss held at 1 each cycle; ctr changes exactly once after release.
  - flush_d_i -> miss = 0 next cycle.
- Target change: a trained branch at 0x100 resolves taken to 0x300 -> miss = 1; the next prediction at 0x100 is 0x300.
